// File: rtl/icache_dm.sv
// Direct-mapped instruction cache: combinational hit path, multi-beat line refill
// over a req/ack handshake, full flush, and saturating hit/miss counters.
module icache_dm #(
  parameter int WIDTH          = 32,
  parameter int ADDR_W         = 32,
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4,
  parameter int CNT_W          = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] PC,
  input  logic              pc_valid,
  input  logic              flush,
  output logic [WIDTH-1:0]  instruction,
  output logic              instr_valid,
  output logic              stall,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [WIDTH-1:0]  mem_rdata,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);

  localparam int OFF   = $clog2(WORDS_PER_LINE);
  localparam int IDX   = $clog2(LINES);
  localparam int TAG_W = ADDR_W - 2 - OFF - IDX;

  typedef enum logic {IDLE, REFILL} state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] data_mem [LINES*WORDS_PER_LINE];
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [LINES-1:0] valid;

  logic [TAG_W-1:0] pc_tag, fill_tag;
  logic [IDX-1:0]   pc_idx, fill_idx;
  logic [OFF-1:0]   pc_off, beat;
  logic             fetch_ok, lookup, hit, miss;
  logic             fill_we, fill_done;
  logic             unused_pc_bits;

  assign pc_off = PC[OFF+1:2];
  assign pc_idx = PC[OFF+IDX+1:OFF+2];
  assign pc_tag = PC[ADDR_W-1:OFF+IDX+2];
  assign unused_pc_bits = ^PC[1:0];

  // Flush and reset both suppress lookups so nothing hits or misses in that cycle.
  assign fetch_ok = RST && pc_valid && !flush && (state == IDLE);
  assign lookup   = valid[pc_idx] && (tag_mem[pc_idx] == pc_tag);
  assign hit      = fetch_ok && lookup;
  assign miss     = fetch_ok && !lookup;

  assign fill_we   = RST && (state == REFILL) && mem_ack && !flush;
  assign fill_done = fill_we && (beat == OFF'(WORDS_PER_LINE - 1));

  always_ff @(posedge CLK) begin
    if (!RST) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    mem_req     = 1'b0;
    mem_addr    = '0;
    instr_valid = hit;
    instruction = data_mem[{pc_idx, pc_off}];
    stall       = pc_valid && !hit;
    case (state)
      IDLE: if (miss) state_nxt = REFILL;
      REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {fill_tag, fill_idx, beat, 2'b00};
        if (flush || fill_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      valid      <= '0;
      beat       <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (flush)          valid           <= '0;
      else if (fill_done) valid[fill_idx] <= 1'b1;
      if (miss)         beat <= '0;
      else if (fill_we) beat <= beat + 1'b1;
      if (hit && hit_count != '1)   hit_count  <= hit_count + 1'b1;
      if (miss && miss_count != '1) miss_count <= miss_count + 1'b1;
    end
  end

  // Storage arrays and the latched refill target carry no reset.
  always_ff @(posedge CLK) begin
    if (miss) begin
      fill_tag <= pc_tag;
      fill_idx <= pc_idx;
    end
    if (fill_we)   data_mem[{fill_idx, beat}] <= mem_rdata;
    if (fill_done) tag_mem[fill_idx]          <= fill_tag;
  end

endmodule

// File: tb/tb_icache_dm.sv
// Scoreboard bench for icache_dm: a line-level cache model predicts hit/miss, refill
// addresses, returned words and stall length; a negedge monitor checks the DUT.
module tb_icache_dm;
  localparam int W  = 4;
  localparam int LN = 16;
  localparam logic [31:0] K = 32'hA5A5A5A5;

  logic        CLK = 1'b0, RST = 1'b0;
  logic [31:0] PC = '0;
  logic        pc_valid = 1'b0, flush = 1'b0, mem_ack = 1'b0;
  logic [31:0] instruction, mem_addr, mem_rdata;
  logic        instr_valid, stall, mem_req;
  logic [15:0] hit_count, miss_count;
  logic [31:0] unused_instr2, unused_addr2;
  logic        unused_iv2, unused_stall2, unused_req2;
  logic [1:0]  hit2, miss2;

  assign mem_rdata = mem_addr ^ K;
  always #5 CLK = ~CLK;

  icache_dm dut (
    .CLK(CLK), .RST(RST), .PC(PC), .pc_valid(pc_valid), .flush(flush),
    .instruction(instruction), .instr_valid(instr_valid), .stall(stall),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .hit_count(hit_count), .miss_count(miss_count));

  // Same stimulus, 2-bit counters: exercises saturation.
  icache_dm #(.CNT_W(2)) dut_sat (
    .CLK(CLK), .RST(RST), .PC(PC), .pc_valid(pc_valid), .flush(flush),
    .instruction(unused_instr2), .instr_valid(unused_iv2), .stall(unused_stall2),
    .mem_req(unused_req2), .mem_addr(unused_addr2), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .hit_count(hit2), .miss_count(miss2));

  typedef struct {
    logic [31:0] instr;
    int          miss;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] addr_q[$];
  int          checks = 0, errors = 0;
  bit          mv[LN];
  logic [31:0] mline[LN];
  int          hits_m = 0, misses_m = 0;
  int          stall_cnt = 0, wait_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat3(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < LN; i++) mv[i] = 1'b0;
  endtask

  // Monitor: address beats, returned words, stall length.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (RST) begin
        if (mem_req) begin
          if (addr_q.size() == 0) chk("mem_req_unexpected", {31'b0, mem_req}, 32'd0);
          else begin
            chk("mem_addr", mem_addr, addr_q[0]);
            if (mem_ack) void'(addr_q.pop_front());
          end
        end
        if (pc_valid) chk("stall", {31'b0, stall}, {31'b0, !instr_valid});
        if (pc_valid && !instr_valid) stall_cnt++;
        if (mem_req && !mem_ack) wait_cnt++;
        if (instr_valid) begin
          if (exp_q.size() == 0) chk("instr_valid_unexpected", {31'b0, instr_valid}, 32'd0);
          else begin
            e = exp_q.pop_front();
            chk("instruction", instruction, e.instr);
            chk("stall_cycles", stall_cnt, e.miss ? (W + 1 + wait_cnt) : 0);
          end
          stall_cnt = 0;
          wait_cnt  = 0;
        end else if (!pc_valid) begin
          stall_cnt = 0;
          wait_cnt  = 0;
        end
      end
    end
  end

  // mode 0: ack always; 1: random ack; 2: ack dropped for 3 cycles at beat 2.
  task automatic fetch(input logic [31:0] pc, input int mode);
    int          idx, n;
    logic [31:0] base;
    exp_t        e;
    idx  = int'((pc >> 4) & 32'hF);
    base = pc & ~32'hF;
    e.instr = (pc & ~32'h3) ^ K;
    e.miss  = !(mv[idx] && mline[idx] == base) ? 1 : 0;
    if (e.miss != 0) begin
      for (int b = 0; b < W; b++) addr_q.push_back(base + 32'(4 * b));
      mv[idx]    = 1'b1;
      mline[idx] = base;
      misses_m++;
    end
    hits_m++;
    exp_q.push_back(e);
    PC = pc;
    pc_valid = 1'b1;
    for (n = 0; n < 64; n++) begin
      case (mode)
        0:       mem_ack = 1'b1;
        1:       mem_ack = ($urandom_range(0, 3) != 0);
        default: mem_ack = !(n >= 3 && n < 6);
      endcase
      @(negedge CLK);
      if (instr_valid) break;
      @(posedge CLK); #1;
    end
    if (n == 64) begin
      checks++;
      errors++;
      $display("FAIL fetch_timeout: pc %h got no instruction, required one within 64 cycles", pc);
      exp_q.delete();
      addr_q.delete();
    end
    @(posedge CLK); #1;
  endtask

  task automatic check_counters();
    pc_valid = 1'b0;
    mem_ack  = 1'b0;
    @(negedge CLK);
    chk("hit_count", 32'(hit_count), hits_m);
    chk("miss_count", 32'(miss_count), misses_m);
    chk("hit_count_sat", 32'(hit2), sat3(hits_m));
    chk("miss_count_sat", 32'(miss2), sat3(misses_m));
    chk("idle_mem_req", {31'b0, mem_req}, 32'd0);
    @(posedge CLK); #1;
  endtask

  function automatic logic [31:0] rand_pc();
    return (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 15)) << 4) |
           (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
  endfunction

  initial begin
    model_clear();
    repeat (2) @(posedge CLK);
    #1;
    pc_valid = 1'b1;
    PC = 32'h100;
    @(negedge CLK);
    chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd1);
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_hit_count", 32'(hit_count), 32'd0);
    chk("rst_miss_count", 32'(miss_count), 32'd0);
    @(posedge CLK); #1;
    RST = 1'b1;
    pc_valid = 1'b0;

    // cold miss, then line hits
    fetch(32'h100, 0);
    fetch(32'h104, 0);
    fetch(32'h108, 0);
    fetch(32'h10C, 0);
    check_counters();
    // conflict eviction
    fetch(32'h500, 0);
    fetch(32'h100, 0);
    check_counters();
    // ack wait cycles at beat 2 of the 0x100 line
    fetch(32'h500, 0);
    fetch(32'h108, 2);
    check_counters();
    // random traffic
    repeat (150) fetch(rand_pc(), 1);
    check_counters();

    // flush at beat 1 of a refill
    fetch(32'h240, 0);
    PC = 32'h7730;
    pc_valid = 1'b1;
    mem_ack = 1'b1;
    for (int b = 0; b < W; b++) addr_q.push_back(32'h7730 + 32'(4 * b));
    misses_m++;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    flush = 1'b1;
    @(posedge CLK); #1;
    flush = 1'b0;
    pc_valid = 1'b0;
    @(negedge CLK);
    chk("flush_mem_req", {31'b0, mem_req}, 32'd0);
    addr_q.delete();
    model_clear();
    @(posedge CLK); #1;
    fetch(32'h7734, 1);
    fetch(32'h240, 1);
    check_counters();

    // reset at beat 2 of a refill
    PC = 32'h7750;
    pc_valid = 1'b1;
    mem_ack = 1'b1;
    for (int b = 0; b < W; b++) addr_q.push_back(32'h7750 + 32'(4 * b));
    repeat (3) begin
      @(posedge CLK); #1;
    end
    RST = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b1;
    pc_valid = 1'b0;
    @(negedge CLK);
    chk("rst2_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst2_mem_addr", mem_addr, 32'd0);
    chk("rst2_instr_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst2_stall", {31'b0, stall}, 32'd0);
    chk("rst2_hit_count", 32'(hit_count), 32'd0);
    chk("rst2_miss_count", 32'(miss_count), 32'd0);
    chk("rst2_hit_count_sat", 32'(hit2), 32'd0);
    addr_q.delete();
    exp_q.delete();
    model_clear();
    hits_m = 0;
    misses_m = 0;
    @(posedge CLK); #1;
    fetch(32'h7750, 0);
    fetch(32'h100, 1);
    check_counters();

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
